// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// Size encodings, FSM states, byte-enable patterns, latched request bundle.
package mem_stage_pkg;

  localparam logic [1:0] MEM_WORD = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_BYTE = 2'b10;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  // Access captured when the stage leaves IDLE.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rt;
    logic [1:0]  size;
    logic        sign;
    logic        we;
    logic [4:0]  rd;
    logic        sel;
    logic        wena;
  } mem_req_t;

  // Half needs addr[0]=0; word (and the 11 alias) needs addr[1:0]=0.
  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic mis;
    mis = 1'b0;
    unique case (size)
      MEM_HALF: mis = a[0];
      MEM_BYTE: mis = 1'b0;
      default:  mis = (a != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
// In: size, a (addr[1:0]), sign, rt, rdata. Out: be, wdata, ldata,
// and misalign when MEM_ALIGN_CHECK_EN is defined.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  a,
  input  logic        sign,
  input  logic [31:0] rt,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  logic [15:0] low16;

  // Addressed bytes moved down to lane 0; an a=3 half sees zeros above.
  assign low16 = 16'(rdata >> {a, 3'b000});

  always_comb begin
    be    = BE_WORD;
    wdata = rt;
    unique case (size)
      MEM_HALF: begin
        be    = a[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata = {2{rt[15:0]}};
      end
      MEM_BYTE: begin
        be    = BE_BYTE0 << a;
        wdata = {4{rt[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ldata = rdata;
    unique case (size)
      MEM_HALF: begin
        ldata = {{16{sign & low16[15]}}, low16};
      end
      MEM_BYTE: begin
        ldata = {{24{sign & low16[7]}}, low16[7:0]};
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_misaligned(size, a);
`endif

endmodule

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: one req/ack data transaction per load/store,
// upstream stall while outstanding, registered write-back payload.
// Ports: execute-side inputs (in_valid_i, dmem_*, alu_result_i, rt_data_i,
// rd_*), bus (mem_req_o/we/addr/be/wdata, mem_ack_i, mem_rdata_i),
// WB outputs (wb_valid_o, rd_waddr_o, rd_wena_o, rd_wdata_o), bus_err_o,
// stall_o. Optional MEM_ALIGN_CHECK_EN adds misalign trapping (misalign_o).
module stage_mem
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  input  logic        dmem_ena_i,
  input  logic        dmem_wena_i,
  input  logic [1:0]  dmem_type_i,
  input  logic        dmem_sign_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rt_data_i,
  input  logic [4:0]  rd_waddr_i,
  input  logic        rd_sel_i,
  input  logic        rd_wena_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  rd_waddr_o,
  output logic        rd_wena_o,
  output logic [31:0] rd_wdata_o,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        misalign_o,
`endif
  output logic        bus_err_o
);

  localparam int unsigned CW =
    (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  mem_state_e  state;
  mem_state_e  state_n;
  mem_req_t    req_q;
  logic [CW-1:0] cnt;

  logic        busy;
  logic        tmo_en;
  logic        expire;
  logic        mis_now;
  logic        accept;
  logic [1:0]  lane_size;
  logic [1:0]  lane_a;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_ldata;

  assign busy   = (state == ST_BUSY);
  assign tmo_en = (TIMEOUT_CYC != 0);
  assign expire = busy & tmo_en & (cnt == CNT_LAST);

  // IDLE looks at the incoming access (misalign check); BUSY at the latch.
  assign lane_size = busy ? req_q.size : dmem_type_i;
  assign lane_a    = busy ? req_q.addr[1:0] : alu_result_i[1:0];

  mem_lane_align u_align (
    .size     (lane_size),
    .a        (lane_a),
    .sign     (req_q.sign),
    .rt       (req_q.rt),
    .rdata    (mem_rdata_i),
    .be       (lane_be),
    .wdata    (lane_wdata),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign (mis_now),
`endif
    .ldata    (lane_ldata)
  );

`ifndef MEM_ALIGN_CHECK_EN
  assign mis_now = 1'b0;
`endif

  assign accept = in_valid_i & dmem_ena_i & ~mis_now;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (accept) state_n = ST_BUSY;
      ST_BUSY: if (mem_ack_i | expire) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // A timeout releases the stall in its last BUSY cycle, like an ack.
  always_comb begin
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    unique case (state)
      ST_IDLE: stall_o = accept & ~rst_i;
      ST_BUSY: begin
        stall_o     = ~(mem_ack_i | expire);
        mem_req_o   = 1'b1;
        mem_we_o    = req_q.we;
        mem_addr_o  = {req_q.addr[31:2], 2'b00};
        mem_be_o    = lane_be;
        mem_wdata_o = lane_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q <= '0;
      cnt   <= '0;
    end else begin
      if (!busy && accept) begin
        req_q.addr <= alu_result_i;
        req_q.rt   <= rt_data_i;
        req_q.size <= dmem_type_i;
        req_q.sign <= dmem_sign_i;
        req_q.we   <= dmem_wena_i;
        req_q.rd   <= rd_waddr_i;
        req_q.sel  <= rd_sel_i;
        req_q.wena <= rd_wena_i;
      end
      if (busy && !mem_ack_i && !expire) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_valid_o <= 1'b0;
      rd_waddr_o <= '0;
      rd_wena_o  <= 1'b0;
      rd_wdata_o <= '0;
      bus_err_o  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
    end else begin
      wb_valid_o <= 1'b0;
      bus_err_o  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
      if (busy) begin
        if (mem_ack_i) begin
          wb_valid_o <= 1'b1;
          rd_waddr_o <= req_q.rd;
          rd_wena_o  <= req_q.wena;
          rd_wdata_o <= req_q.sel ? lane_ldata : req_q.addr;
        end else if (expire) begin
          wb_valid_o <= 1'b1;
          rd_waddr_o <= req_q.rd;
          rd_wena_o  <= 1'b0;
          rd_wdata_o <= req_q.addr;
          bus_err_o  <= 1'b1;
        end
      end else if (in_valid_i && (!dmem_ena_i || mis_now)) begin
        wb_valid_o <= 1'b1;
        rd_waddr_o <= rd_waddr_i;
        rd_wena_o  <= rd_wena_i & ~mis_now;
        rd_wdata_o <= alu_result_i;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_o <= mis_now;
`endif
      end
    end
  end

endmodule
